cla_word_sequencer: RTL and testbench

//   Multi-cycle add/subtract sequencer for wide operands built on one shared
//   4-bit CLA slice (module CLA: A[3:0], B[3:0], Cin -> Sum[3:0], Cout).

---
 rtl/cla_word_sequencer.sv | 167 ++++++++++++++++
 tb/tb_cla_word_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: multi-cycle WIDTH-bit add/subtract built on one shared
// 4-bit carry-lookahead slice. Operands are latched on accept, then processed
// one nibble per cycle, LSB first. The inter-slice carry lives in a register.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid & ready are both high. The producer holds in_valid/a/b/cin/sub until
// that edge. out_valid is held, with sum/cout/ovf stable, until the consumer
// raises out_ready on an edge. No combinational path from any in_* to any
// out_* exists; every output is a function of registered state only.

// 4-bit carry-lookahead adder slice.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module cla_word_sequencer #(
    parameter int NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NSLICE-1:0]   a,
    input  logic [4*NSLICE-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NSLICE-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);
    localparam int WIDTH = 4 * NSLICE;
    localparam int IW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB   = WIDTH - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_sum;
    logic             sl_cout;
    logic             accept;
    logic             last_slice;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid & in_ready;
    assign last_slice = (idx == LAST_IDX);

    // Select the current nibble of each latched operand.
    always_comb begin
        sl_a = 4'd0;
        sl_b = 4'd0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) begin
                sl_a = op_a[4*i +: 4];
                sl_b = op_b[4*i +: 4];
            end
        end
    end

    cla u_cla (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last
    // slice, DONE -> IDLE once the consumer takes the result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one slice per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= a;
                        // Subtraction is a + ~b + 1; cin is ignored then.
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IW'(i)) sum[4*i +: 4] <= sl_sum;
                    end
                    carry <= sl_cout;
                    if (last_slice) begin
                        // Index stays put so it never selects a stale slice.
                        cout <= sl_cout;
                        ovf  <= (op_a[MSB] == op_b[MSB]) && (sl_sum[3] != op_a[MSB]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench for cla_word_sequencer: a NSLICE=4 instance for the main
// scenarios plus a NSLICE=1 instance for the single-slice corner case.
module tb_cla_word_sequencer;
    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
    logic [15:0] a, b, sum;

    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1, busy1;
    logic [3:0]  a1, b1, sum1;

    int n_checks;
    int n_fail;

    cla_word_sequencer #(.NSLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    cla_word_sequencer #(.NSLICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one operation through the NSLICE=4 instance and checks latency,
    // result and return to IDLE.
    task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tsub, input logic [15:0] esum,
                          input logic ecout, input logic eovf);
        int n;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready_before: got %b want 1", name, in_ready);
        end
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges want 4", name, n);
        end
        n_checks++;
        if ({sum, cout, ovf} !== {esum, ecout, eovf}) begin
            n_fail++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, esum, ecout, eovf);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s return_idle: got valid/ready/busy=%b%b%b want 010",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, busy, sum, cout, ovf} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b busy=%b sum=%h cout=%b ovf=%b want all 0",
                     out_valid, busy, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        run_op("zero",     16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin_add",  16'h00DD, 16'h00BB, 1'b1, 1'b0, 16'h0199, 1'b0, 1'b0);
        run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_neg",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_sub();
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_cin",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_ovf_c", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d edges want 4", n);
        end
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, in_ready, busy, sum, cout, ovf} !== {3'b101, 16'h3333, 2'b00}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 1 3333 0 0",
                         i, out_valid, in_ready, busy, sum, cout, ovf);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 0; sub = 0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, sum, cout, ovf} !== 20'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got valid=%b busy=%b sum=%h cout=%b ovf=%b want all 0",
                     out_valid, busy, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_in_ready: got %b want 1", in_ready);
        end
        run_op("after_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    endtask

    task automatic test_nslice1();
        int n;
        @(negedge clk);
        a1 = 4'hF; b1 = 4'h1; cin1 = 0; sub1 = 0; in_valid1 = 1'b1;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        n = 0;
        while (out_valid1 !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL n1_latency: got %0d edges want 1", n);
        end
        n_checks++;
        if ({sum1, cout1} !== {4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL n1_result: got sum=%h cout=%b want sum=0 cout=1", sum1, cout1);
        end
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1 out_ready1 = 1'b0;
        n_checks++;
        if ({out_valid1, in_ready1} !== 2'b01) begin
            n_fail++;
            $display("FAIL n1_return_idle: got valid=%b ready=%b want 0 1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_nslice1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
